// File: rtl/fila_param.sv
`default_nettype none
// ============================================================================
// Module   : fila_param
// Summary  : Parametrised synchronous circular-buffer FIFO with occupancy,
//            full/empty/almost-full flags, sticky errors and flush.
// Revision : 1.0 - initial release
// ============================================================================
module fila_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int LEN_W     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
  input  logic              flush_in,
  input  logic              clear_err_in,
  output logic [DATA_W-1:0] data_out,
  output logic [LEN_W-1:0]  len_out,
  output logic              empty_out,
  output logic              full_out,
  output logic              almost_full_out,
  output logic              overflow_err_out,
  output logic              underflow_err_out
);

  localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]   c_DEPTH    = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0]   c_AF       = LEN_W'(AF_THRESH);
  localparam logic [LEN_W-1:0]   c_ONE      = LEN_W'(1);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [LEN_W-1:0]   r_len;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_empty;
  logic               r_full;
  logic               r_af;
  logic               r_ovf;
  logic               r_udf;

  logic               w_deq_ok;
  logic               w_enq_ok;
  logic               w_ovf_evt;
  logic               w_udf_evt;
  logic [LEN_W-1:0]   w_len_next;

  // A pop frees a slot on the same edge, so a full FIFO can still take a push.
  always_comb begin
    w_deq_ok   = dequeue_in && (r_len != '0);
    w_enq_ok   = enqueue_in && ((r_len != c_DEPTH) || w_deq_ok);
    w_ovf_evt  = !flush_in && enqueue_in && !w_enq_ok;
    w_udf_evt  = !flush_in && dequeue_in && !w_deq_ok;
    w_len_next = r_len;
    if (flush_in) begin
      w_len_next = '0;
    end else if (w_enq_ok && !w_deq_ok) begin
      w_len_next = r_len + c_ONE;
    end else if (!w_enq_ok && w_deq_ok) begin
      w_len_next = r_len - c_ONE;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_10KHz) begin
    if (!reset && !flush_in && w_enq_ok) begin
      r_mem[r_tail] <= data_in;
    end
  end

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_len      <= '0;
      r_data_out <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_af       <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (flush_in) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_enq_ok) begin
          r_tail <= (r_tail == c_LAST_PTR) ? '0 : r_tail + c_PTR_W'(1);
        end
        if (w_deq_ok) begin
          r_head     <= (r_head == c_LAST_PTR) ? '0 : r_head + c_PTR_W'(1);
          r_data_out <= r_mem[r_head];
        end
      end
      r_len   <= w_len_next;
      r_empty <= (w_len_next == '0);
      r_full  <= (w_len_next == c_DEPTH);
      r_af    <= (w_len_next >= c_AF);
      // A fresh error event wins over a same-cycle clear.
      r_ovf   <= w_ovf_evt || (r_ovf && !clear_err_in);
      r_udf   <= w_udf_evt || (r_udf && !clear_err_in);
    end
  end

  assign data_out          = r_data_out;
  assign len_out           = r_len;
  assign empty_out         = r_empty;
  assign full_out          = r_full;
  assign almost_full_out   = r_af;
  assign overflow_err_out  = r_ovf;
  assign underflow_err_out = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_fila_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fila_param
// Summary  : Directed table-driven bench for fila_param (DEPTH=8, AF=6).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fila_param;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       enq, deq, flush, clr;
  logic [7:0] data_out;
  logic [7:0] len_out;
  logic       empty_out, full_out, af_out, ovf_out, udf_out;

  int n_vec = 0;
  int n_bad = 0;

  fila_param #(.DATA_W(8), .DEPTH(8), .LEN_W(8), .AF_THRESH(6)) dut (
    .clk_10KHz        (clk),
    .reset            (rst),
    .data_in          (data_in),
    .enqueue_in       (enq),
    .dequeue_in       (deq),
    .flush_in         (flush),
    .clear_err_in     (clr),
    .data_out         (data_out),
    .len_out          (len_out),
    .empty_out        (empty_out),
    .full_out         (full_out),
    .almost_full_out  (af_out),
    .overflow_err_out (ovf_out),
    .underflow_err_out(udf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, enq, deq, fl, clr;
    logic [7:0] din;
    logic [7:0] len;
    logic [7:0] dout;
    logic       ov, ud;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input logic d, input logic f,
                              input logic c, input logic [7:0] din, input logic [7:0] len,
                              input logic [7:0] dout, input logic ov, input logic ud);
    vec_t v;
    v.rst = r; v.enq = e; v.deq = d; v.fl = f; v.clr = c; v.din = din;
    v.len = len; v.dout = dout; v.ov = ov; v.ud = ud;
    tbl.push_back(v);
  endfunction

  // One clock per vector; outputs checked 1 ns after the rising edge.
  task automatic apply(input vec_t v, input string name);
    logic ee, ef, eaf;
    rst = v.rst; enq = v.enq; deq = v.deq; flush = v.fl; clr = v.clr; data_in = v.din;
    @(posedge clk);
    #1;
    ee  = (v.len == 8'd0);
    ef  = (v.len == 8'd8);
    eaf = (v.len >= 8'd6);
    n_vec++;
    if (len_out !== v.len || data_out !== v.dout || empty_out !== ee || full_out !== ef ||
        af_out !== eaf || ovf_out !== v.ov || udf_out !== v.ud) begin
      n_bad++;
      $display("FAIL %s: got len=%0d dout=%h e=%b f=%b af=%b ov=%b ud=%b, want len=%0d dout=%h e=%b f=%b af=%b ov=%b ud=%b",
               name, len_out, data_out, empty_out, full_out, af_out, ovf_out, udf_out,
               v.len, v.dout, ee, ef, eaf, v.ov, v.ud);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic f,
                      input logic c, input logic [7:0] din, input logic [7:0] len,
                      input logic [7:0] dout, input logic ov, input logic ud, input string name);
    vec_t v;
    v.rst = r; v.enq = e; v.deq = d; v.fl = f; v.clr = c; v.din = din;
    v.len = len; v.dout = dout; v.ov = ov; v.ud = ud;
    apply(v, name);
  endtask

  initial begin
    rst = 1'b1; enq = 1'b0; deq = 1'b0; flush = 1'b0; clr = 1'b0; data_in = 8'h00;

    // Reset, fill past full, drain past empty.
    add(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 1, 0, 0, 0, 8'(i * 17), (i < 8) ? 8'(i + 1) : 8'd8, 8'h00, (i >= 8), 0);
    for (int j = 0; j < 9; j++)
      add(0, 0, 1, 0, 0, 8'h00, (j < 8) ? 8'(7 - j) : 8'd0, (j < 8) ? 8'(j * 17) : 8'h77,
          1, (j == 8));
    add(0, 0, 0, 0, 1, 8'h00, 0, 8'h77, 0, 0);

    // Pointer wrap: 5 through, then 8 more starting at slot 5.
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 8'(8'h10 + i), 8'(i + 1), 8'h77, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 8'h00, 8'(4 - i), 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 0, 8'(8'hA0 + i), 8'(i + 1), 8'h14, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 0, 8'h00, 8'(7 - i), 8'(8'hA0 + i), 0, 0);

    // Simultaneous push/pop at len 3.
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 8'(8'hB0 + i), 8'(i + 1), 8'hA7, 0, 0);
    add(0, 1, 1, 0, 0, 8'hC0, 3, 8'hB0, 0, 0);
    add(0, 1, 1, 0, 0, 8'hC1, 3, 8'hB1, 0, 0);
    add(0, 1, 1, 0, 0, 8'hC2, 3, 8'hB2, 0, 0);
    add(0, 1, 1, 0, 0, 8'hC3, 3, 8'hC0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 8'h00, 8'(2 - i), 8'(8'hC1 + i), 0, 0);

    // Simultaneous push/pop at full: no overflow, len holds.
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 0, 8'(8'hD0 + i), 8'(i + 1), 8'hC3, 0, 0);
    add(0, 1, 1, 0, 0, 8'hE0, 8, 8'hD0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 0, 0, 8'h00, 8'(7 - i), 8'(8'hD1 + i), 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 0, 8'hE0, 0, 0);

    // Simultaneous push/pop at empty: push wins, pop underflows, no bypass.
    add(0, 1, 1, 0, 0, 8'hF0, 1, 8'hE0, 0, 1);
    add(0, 0, 1, 0, 0, 8'h00, 0, 8'hF0, 0, 1);

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("tbl[%0d]", k));

    // Flush at len 5 with a concurrent push.
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 0, 0, 8'(8'h21 + i), 8'(i + 1), 8'hF0, 0, 1, "flush_fill");
    step(0, 1, 0, 1, 0, 8'h26, 0, 8'hF0, 0, 1, "flush");
    step(0, 0, 1, 0, 0, 8'h00, 0, 8'hF0, 0, 1, "post_flush_pop");
    step(0, 0, 1, 0, 1, 8'h00, 0, 8'hF0, 0, 1, "clr_vs_event");
    step(0, 1, 1, 0, 0, 8'h27, 1, 8'hF0, 0, 1, "overfill_seed");
    for (int i = 0; i < 7; i++)
      step(0, 1, 0, 0, 0, 8'h28, 8'(i + 2), 8'hF0, 0, 1, "overfill");
    step(0, 1, 0, 0, 0, 8'h29, 8, 8'hF0, 1, 1, "overflow");
    step(0, 0, 0, 0, 1, 8'h00, 8, 8'hF0, 0, 0, "clear_err");
    step(0, 0, 1, 0, 0, 8'h00, 7, 8'h27, 0, 0, "pop_after_flush");

    // Reset mid-stream at len 4.
    step(0, 0, 0, 1, 0, 8'h00, 0, 8'h27, 0, 0, "flush2");
    step(0, 0, 1, 0, 0, 8'h00, 0, 8'h27, 0, 1, "udf_seed");
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 0, 0, 8'(8'h31 + i), 8'(i + 1), 8'h27, 0, 1, "pre_reset_fill");
    step(1, 1, 1, 0, 0, 8'h35, 0, 8'h00, 0, 0, "mid_reset");
    step(0, 1, 0, 0, 0, 8'h5A, 1, 8'h00, 0, 0, "push_5a");
    step(0, 0, 1, 0, 0, 8'h00, 0, 8'h5A, 0, 0, "pop_5a");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fila_param.md
Name: fila_param

Overview:
- Parametrised successor to the 8-bit queue: a synchronous circular-buffer FIFO with configurable data width, depth and almost-full threshold.
- Adds full/empty/almost-full flags, sticky overflow/underflow error flags, synchronous flush, and defined simultaneous enqueue/dequeue.
- Sits between producer logic (e.g. switch/keypad capture) and consumer logic (display/serial) in the 10 kHz clock domain.

Parameters:
- DATA_W, 8, width of data_in/data_out in bits.
- DEPTH, 8, number of storage entries; legal range 2..255, not required to be a power of two.
- LEN_W, 8, width of len_out; must satisfy 2**LEN_W > DEPTH.
- AF_THRESH, 6, almost_full_out asserts when len >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk_10KHz  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  write data, sampled on the rising edge when the enqueue is accepted.
- enqueue_in  in  1  level-sensitive; one push per clock while high.
- dequeue_in  in  1  level-sensitive; one pop per clock while high.
- flush_in  in  1  synchronous empty request.
- clear_err_in  in  1  clears the sticky error flags.
- data_out  out  DATA_W  registered value of the most recently popped entry.
- len_out  out  LEN_W  current occupancy, 0..DEPTH.
- empty_out  out  1  high when len == 0.
- full_out  out  1  high when len == DEPTH.
- almost_full_out  out  1  high when len >= AF_THRESH.
- overflow_err_out  out  1  sticky; an enqueue was attempted while full and not accepted.
- underflow_err_out  out  1  sticky; a dequeue was attempted while empty.

Behaviour:
- Reset (synchronous, highest priority):
  - head, tail and len go to 0; data_out = 0; empty_out = 1; full_out = 0; almost_full_out = 0; both error flags = 0.
  - Storage array contents are not cleared.
  - Reset during traffic discards all queued data on that edge.
- Flush (priority below reset, above all else):
  - head = tail = len = 0.
  - data_out and the error flags hold their values.
  - enqueue_in and dequeue_in are ignored in that cycle.
- Acceptance:
  - deq_ok = dequeue_in && len != 0.
  - enq_ok = enqueue_in && (len != DEPTH || deq_ok).
- Enqueue: mem[tail] <= data_in; tail <= (tail == DEPTH-1) ? 0 : tail+1. Wrap uses an explicit compare, not a modulo on the pointer width.
- Dequeue: data_out <= mem[head] in the same edge; head advances with the same wrap rule. Latency is 1 clock: data_out is valid the cycle after the popping edge and holds until the next accepted pop.
- Occupancy:
  - len += 1 on enq_ok only.
  - len -= 1 on deq_ok only.
  - len unchanged when both or neither are accepted.
- Simultaneous enqueue and dequeue:
  - When empty: the enqueue is accepted and the dequeue is rejected (counts as underflow). The word is not bypassed to data_out.
  - When full: both are accepted, len stays DEPTH, and no overflow is flagged.
  - Otherwise: both are accepted, len is unchanged.
- Errors:
  - overflow_err_out sets on enqueue_in && !enq_ok.
  - underflow_err_out sets on dequeue_in && !deq_ok.
  - Both are sticky until clear_err_in or reset.
  - If clear_err_in and a new error event occur in the same cycle, the flag ends set.
- Flags: all registered, derived from the next-state len, so they agree with len_out in the same cycle.

Test Plan:
- Reset, then enqueue_in=1 for 10 clocks with data 0x00,0x11,…,0x99 (DEPTH=8) -> 0x00..0x77 stored; len_out 1..8; almost_full_out high at len 6; full_out high from len 8; overflow_err_out high after the 0x88 attempt; len stays 8.
- From full, 9 single-cycle dequeues -> data_out 0x00,0x11,…,0x77 (one per pop, 1-clock latency); len 8→0; empty_out high; 9th pop sets underflow_err_out and data_out holds 0x77.
- Wrap-around: push 5, pop 5, then push 0xA0..0xA7 and pop all 8 -> order preserved across the pointer wrap; len peaks at 8.
- Simultaneous ops: at len 3, enqueue+dequeue for 4 clocks -> len constant 3, FIFO order kept. At full, enqueue+dequeue -> len 8 and no overflow. At empty, enqueue+dequeue -> len 1, underflow_err_out set, data_out unchanged.
- Flush at len 5 with enqueue_in=1 -> next cycle len 0, empty_out 1, data_out unchanged. clear_err_in then drops both error flags.
- Reset mid-stream at len 4 -> next cycle all outputs at reset values; subsequent push/pop of 0x5A returns 0x5A.
